dmem_sync: RTL
==============

# dmem_sync

Parametrised single-port data memory for the ARM datapath, replacing the fixed 256×32 data memory. It adds byte-lane write enables, a registered read with a valid/ready request handshake, and an optional post-reset clear sequencer that zeroes the array one word per cycle. It sits between the load/store stage and the memory-stage pipeline register.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 8, word-address width.
- DEPTH, 1<<ADDR_W, number of words. Derived; not overridden independently.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte-lane write enables; bit i gates bits [8i+7:8i].
- rsp_valid  out  1  read data valid, a one-cycle pulse.
- rsp_rdata  out  DATA_W  read data.
- busy  out  1  clear sequence in progress.

## Operation
- A request is accepted when req_valid && req_ready at a rising edge.
- **Accepted write:** each lane with req_be[i]=1 is written; lanes with req_be[i]=0 keep their old value. req_be=0 is a legal no-op. A write produces no response.
- **Accepted read:** rsp_valid=1 and rsp_rdata=mem[addr] in the following cycle.
  - rsp_rdata holds its last read value until the next read; it is not cleared when rsp_valid drops.
  - There is no response backpressure; the consumer must take the data in the rsp_valid cycle.
- The block is single-port, with one access per cycle.
  - A read accepted in the cycle after a write to the same address returns the newly written data.
- Every address in 0..DEPTH-1 is valid. There is no out-of-range case.
- FSM (with the clear feature) has two states, CLEAR and READY:
  - rst drives the FSM to CLEAR and sets clr_cnt=0.
  - CLEAR: each cycle writes 0 to mem[clr_cnt] and increments clr_cnt. When clr_cnt==DEPTH-1 the FSM moves to READY on that edge.
  - In CLEAR, req_ready=0 and busy=1. req_valid is ignored: nothing is accepted and memory is unaffected except by the sweep.
  - READY: req_ready=1 and busy=0. The FSM stays in READY until rst.
- Reset asserted mid-clear or mid-operation aborts everything: the sweep restarts from address 0, and any pending rsp_valid is dropped.

## Timing
- Values while rst is asserted:
  - With DMEM_CLEAR_EN: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0.
  - Without DMEM_CLEAR_EN: req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0.
- Clear duration is exactly DEPTH cycles after rst deasserts. With DEPTH=256, req_ready rises after the 256th rising edge following release.
- Read latency is 1 cycle from acceptance to rsp_valid. Throughput is one request per cycle.
- Write-to-read visibility is 1 cycle: the read accepted at edge N+1 sees the write accepted at edge N.
- req_ready is a function of FSM state only; it never depends combinationally on req_valid.

## Configuration
- DMEM_CLEAR_EN defined:
  - The CLEAR state, clr_cnt and busy logic are compiled in.
  - Memory reads 0 everywhere once busy falls.
- DMEM_CLEAR_EN undefined:
  - There is no FSM; req_ready=1 out of reset and busy is tied to 0.
  - Array contents are not reset and keep their prior values across rst. This makes the array inferable as block RAM.

## Structure
- Package dmem_pkg holds:
  - the state enum (CLEAR, READY);
  - the default DATA_W and ADDR_W;
  - the BE_W = DATA_W/8 helper constant.
- Sub-module dmem_array holds the storage: one write port with per-lane enables, a synchronous read, and no reset.
  - The top level holds the FSM, the clear counter, the handshake, and the write-port mux between clear and request.

## Test plan
1. **Post-reset clear:** pulse rst, then release → busy=1 and req_ready=0 for 256 cycles, then req_ready=1. A read of address 0x06 then returns 0x00000000 with rsp_valid one cycle after acceptance.
2. **Full-word write/read:** write 0x10 with data 0xDEADBEEF and be=0xF, then read 0x10 the next cycle → rsp_valid pulses with rsp_rdata=0xDEADBEEF.
3. **Partial write:** starting from test 2, write 0x10 with data 0x0000AA00 and be=0x2, then read → 0xDEADAAEF.
4. **Requests during clear:** hold req_valid=1, req_we=1, addr 0x20, data 0xFFFFFFFF throughout CLEAR → no request is accepted while busy=1 and rsp_valid never pulses. After busy falls, a read of 0x20 returns 0.
5. **Reset mid-clear:** assert rst at clear cycle 100, then release → busy stays high a full 256 cycles after release, and rsp_valid stays 0 throughout.
6. **Back-to-back reads:** issue reads of 0x10 then 0x11 on consecutive cycles → rsp_valid is high for 2 consecutive cycles with the matching data, in order, and rsp_rdata holds the 0x11 value afterwards.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and default sizes for the dmem_sync data memory.
//                The FSM state type is only used when DMEM_CLEAR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;
    localparam int BE_W       = DEF_DATA_W / 8;

    // Post-reset sweep, then normal operation until the next reset.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Number of byte lanes for a given word width.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Single-port storage array with per-byte-lane write enables
//                and a registered read. No reset, so it maps onto block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic [DATA_W/8-1:0]     be_i,
    output logic [DATA_W-1:0]       rdata_o
);

    localparam int LANES = be_width(DATA_W);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Lane-gated write; disabled lanes keep their stored byte.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Read register updates only on reads, so the last read word is held.
    always_ff @(posedge clk) begin
        if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_sync.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_sync
//  Description : Parametrised single-port data memory with byte-lane writes,
//                1-cycle registered read and valid/ready request handshake.
//                Define DMEM_CLEAR_EN to compile in the post-reset sweep that
//                zeroes the array one word per cycle (busy high meanwhile).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_sync
    import dmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    input  logic [DATA_W/8-1:0]     req_be,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    busy
);

    localparam int LANES = be_width(DATA_W);

    logic                    w_clearing;
    logic [ADDR_W-1:0]       clr_cnt_q;
    logic                    w_accept;
    logic                    w_arr_en;
    logic                    w_arr_we;
    logic [ADDR_W-1:0]       w_arr_addr;
    logic [DATA_W-1:0]       w_arr_wdata;
    logic [LANES-1:0]        w_arr_be;
    logic [DATA_W-1:0]       w_arr_rdata;
    logic                    rsp_valid_q;
    logic                    rd_seen_q;

`ifdef DMEM_CLEAR_EN
    localparam int DEPTH = 1 << ADDR_W;

    state_e                  state_q;
    state_e                  state_d;
    logic [ADDR_W-1:0]       clr_cnt_d;

    // State and sweep counter; reset restarts the sweep at word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Sweep one word per cycle, leave CLEAR on the edge that writes the last word.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign w_clearing = (state_q == ST_CLEAR);
`else
    assign w_clearing = 1'b0;
    assign clr_cnt_q  = '0;
`endif

    // Ready depends on FSM state only, never on req_valid.
    assign req_ready = ~w_clearing;
    assign busy      = w_clearing;
    assign w_accept  = req_valid & req_ready;

    // Single write/read port shared between the sweep and accepted requests.
    assign w_arr_en    = w_clearing | w_accept;
    assign w_arr_we    = w_clearing | (w_accept & req_we);
    assign w_arr_addr  = w_clearing ? clr_cnt_q : req_addr;
    assign w_arr_wdata = w_clearing ? '0 : req_wdata;
    assign w_arr_be    = w_clearing ? '1 : req_be;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .en_i    (w_arr_en),
        .we_i    (w_arr_we),
        .addr_i  (w_arr_addr),
        .wdata_i (w_arr_wdata),
        .be_i    (w_arr_be),
        .rdata_o (w_arr_rdata)
    );

    // Response pulse and a flag that forces rsp_rdata to 0 until a read after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rd_seen_q   <= 1'b0;
        end else begin
            rsp_valid_q <= w_accept & ~req_we;
            if (w_accept && !req_we) begin
                rd_seen_q <= 1'b1;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rd_seen_q ? w_arr_rdata : '0;

endmodule
`default_nettype wire
